accu_exec_unit: RTL and testbench
=================================

Name: accu_exec_unit

Overview:
- Multi-cycle execute sequencer for the 8-bit accumulator processor; sits directly upstream of the data memory.
- Accepts one instruction word at a time from the fetch stage and holds the accumulator and flags.
- Drives the data memory address, write-enable and write-data lines, and consumes the memory's read data.
- Executes load, store, ALU and halt instructions.

Parameters:
DataWidth, 8, accumulator / memory data width
AddrWidth, 8, data memory address width (operand field width)

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
InstrValid  input  1  instruction word present on Instr
Instr  input  16  [15:12] opcode, [11:8] reserved (ignored), [7:0] operand / address
InstrReady  output  1  unit can accept an instruction this cycle
MemAddr  output  AddrWidth  data memory address
MemWriteEnable  output  1  data memory write strobe
MemWData  output  DataWidth  data memory write data; always equals Accu
MemRData  input  DataWidth  data memory read data
Accu  output  DataWidth  accumulator
Zero  output  1  set when last accumulator write was 0
Carry  output  1  carry (ADD) / borrow (SUB)
Halted  output  1  HLT executed

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs registered except MemWData (continuous copy of Accu).
  - Accu=0, Zero=1, Carry=0, MemAddr=0, MemWriteEnable=0, Halted=0.
  - State=IDLE; InstrReady=1 one cycle after Reset deasserts.
- Reset asserted mid-operation: everything returns to reset values immediately. MemWriteEnable drops without waiting for an edge. The in-flight instruction is discarded.
- States: IDLE, DECODE, MEM_RD, MEM_WAIT, EXEC, MEM_WR, HALTED.
- InstrReady is 1 only in IDLE.
- Handshake: InstrValid && InstrReady at a rising edge latches Instr and moves to DECODE. With InstrValid=0 in IDLE, the unit stays in IDLE. Instr is don't-care when not accepted.
- DECODE: MemAddr <= operand for memory opcodes; next state depends on opcode.
- Opcodes:
  - 0 NOP: -> IDLE.
  - 1 LDI: -> EXEC; Accu=operand.
  - 2 LDA: -> MEM_RD; Accu=MemRData.
  - 3 STA: -> MEM_WR.
  - 4 ADD: via MEM_RD; {Carry,Accu} = Accu + M, 9-bit result.
  - 5 SUB: via MEM_RD; Accu = Accu - M mod 256; Carry = 1 if Accu < M (unsigned), else 0.
  - 6 AND, 7 OR, 8 XOR: via MEM_RD; bitwise operation; Carry unchanged.
  - F HLT: -> HALTED.
  - All other opcodes: NOP.
- MEM_RD -> MEM_WAIT -> EXEC. MemAddr is held through both states and MemWriteEnable=0. The memory has one-cycle read latency; MemRData is sampled at the end of MEM_WAIT into an internal operand register M.
- EXEC: Accu updated; Zero = (new Accu == 0); -> IDLE.
- Zero is updated on every accumulator write (LDI, LDA, ALU ops). Zero and Carry are unchanged by NOP and STA.
- LDA leaves Carry unchanged.
- MEM_WR: MemWriteEnable=1 for exactly this one cycle, with MemAddr=operand and MemWData=Accu; -> IDLE. MemWriteEnable is 0 in every other state.
- Latency, accept edge to InstrReady high again:
  - NOP: 2 cycles
  - LDI, STA: 3 cycles
  - LDA, ADD, SUB, AND, OR, XOR: 5 cycles
- HALTED: Halted=1, InstrReady=0, no memory activity; left only by Reset.
- MemAddr holds its last value outside memory states.

Optional Feature:
ACCU_EXEC_IMM_ALU_EN
- Defined: opcodes 9 ADDI and A SUBI use the operand field as the immediate M. Path DECODE -> EXEC -> IDLE, 3-cycle latency, with the same Carry/Zero rules as ADD/SUB. No memory access.
- Undefined: opcodes 9 and A decode as NOP, with 2-cycle latency.

Test Plan:
- Reset, then LDI 0x3C -> Accu=0x3C, Zero=0, InstrReady low for 2 cycles then high 3 cycles after accept.
- LDI 0x5A, STA 0x10 -> exactly one cycle of MemWriteEnable=1, MemAddr=0x10, MemWData=0x5A; Accu unchanged.
- Memory model holds [0x20]=0xF0; LDI 0x20, ADD 0x20 -> Accu=0x10, Carry=1, Zero=0; ADD completes 5 cycles after accept.
- Memory [0x21]=0x05; LDI 0x05, SUB 0x21 -> Accu=0x00, Zero=1, Carry=0. Then LDI 0x01, SUB 0x21 -> Accu=0xFC, Carry=1.
- HLT -> Halted=1, InstrReady=0 while InstrValid=1 for 10 cycles. Then assert Reset asynchronously during a MEM_WR cycle of a following STA -> MemWriteEnable falls before the next edge; all outputs return to reset values.
- With ACCU_EXEC_IMM_ALU_EN, LDI 0xFF then ADDI 0x01 -> Accu=0x00, Carry=1, Zero=1, no memory access. Without the macro, the same sequence leaves Accu=0xFF.

Source files
------------

// File: rtl/accu_exec_unit.sv
// -----------------------------------------------------------------------------
// accu_exec_unit
//   Multi-cycle execute sequencer for the 8-bit accumulator processor. It takes
//   one instruction at a time from fetch, owns the accumulator and the
//   Zero/Carry flags, and drives the data-memory port (one-cycle read latency).
//
//   Optional build macro: ACCU_EXEC_IMM_ALU_EN
//     defined   -> opcodes 9 (ADDI) and A (SUBI) use the operand as immediate
//     undefined -> opcodes 9 and A behave as NOP
//
// Ports
//   clk             in   rising-edge clock
//   Reset           in   asynchronous, active-high reset
//   InstrValid      in   instruction word present on Instr
//   Instr[15:0]     in   [15:12] opcode, [11:8] reserved, [7:0] operand/address
//   InstrReady      out  unit accepts an instruction this cycle (IDLE only)
//   MemAddr         out  data-memory address
//   MemWriteEnable  out  data-memory write strobe (MEM_WR only)
//   MemWData        out  data-memory write data, continuous copy of Accu
//   MemRData        in   data-memory read data
//   Accu            out  accumulator
//   Zero            out  last accumulator write was zero
//   Carry           out  carry (ADD) / borrow (SUB)
//   Halted          out  HLT has executed; cleared only by Reset
// -----------------------------------------------------------------------------
module accu_exec_unit #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 InstrValid,
  input  logic [15:0]          Instr,
  output logic                 InstrReady,
  output logic [AddrWidth-1:0] MemAddr,
  output logic                 MemWriteEnable,
  output logic [DataWidth-1:0] MemWData,
  input  logic [DataWidth-1:0] MemRData,
  output logic [DataWidth-1:0] Accu,
  output logic                 Zero,
  output logic                 Carry,
  output logic                 Halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
`ifdef ACCU_EXEC_IMM_ALU_EN
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;
`endif
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_MEM_RD   = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_EXEC     = 3'd4,
    S_MEM_WR   = 3'd5,
    S_HALTED   = 3'd6
  } state_t;

  state_t               state;
  logic [3:0]           op_q;
  logic [7:0]           opd_q;
  logic [DataWidth-1:0] m_q;      // ALU / load operand (memory data or immediate)
  logic [DataWidth:0]   exec_res; // {carry, result}
  logic                 unused_rsvd;

  // Reserved instruction bits carry no meaning for this unit.
  assign unused_rsvd = ^Instr[11:8];

  assign MemWData = Accu;

  // Computes {carry, new accumulator}. Loads and logic ops pass the old carry
  // through so the EXEC stage can write both fields unconditionally.
  function automatic logic [DataWidth:0] alu(
    input logic [3:0]           op,
    input logic [DataWidth-1:0] a,
    input logic [DataWidth-1:0] b,
    input logic                 c
  );
    logic [DataWidth:0] r;
    case (op)
      OP_LDI, OP_LDA: r = {c, b};
`ifdef ACCU_EXEC_IMM_ALU_EN
      OP_ADD, OP_ADDI: r = {1'b0, a} + {1'b0, b};
      // Borrow out of the 9-bit difference is exactly (a < b) unsigned.
      OP_SUB, OP_SUBI: r = {1'b0, a} - {1'b0, b};
`else
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      OP_SUB: r = {1'b0, a} - {1'b0, b};
`endif
      OP_AND: r = {c, a & b};
      OP_OR:  r = {c, a | b};
      OP_XOR: r = {c, a ^ b};
      default: r = {c, a};
    endcase
    return r;
  endfunction

  assign exec_res = alu(op_q, Accu, m_q, Carry);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state          <= S_IDLE;
      InstrReady     <= 1'b0;
      op_q           <= '0;
      opd_q          <= '0;
      m_q            <= '0;
      Accu           <= '0;
      Zero           <= 1'b1;
      Carry          <= 1'b0;
      MemAddr        <= '0;
      MemWriteEnable <= 1'b0;
      Halted         <= 1'b0;
    end else begin
      InstrReady     <= 1'b0;
      MemWriteEnable <= 1'b0;
      case (state)
        // Ready rises one cycle after entering IDLE, which sets the
        // accept-to-ready latencies (NOP 2, LDI/STA 3, memory ALU 5).
        S_IDLE: begin
          if (InstrValid && InstrReady) begin
            op_q  <= Instr[15:12];
            opd_q <= Instr[7:0];
            state <= S_DECODE;
          end else begin
            InstrReady <= 1'b1;
          end
        end

        S_DECODE: begin
          case (op_q)
            OP_LDI: begin
              m_q   <= DataWidth'(opd_q);
              state <= S_EXEC;
            end
`ifdef ACCU_EXEC_IMM_ALU_EN
            OP_ADDI, OP_SUBI: begin
              m_q   <= DataWidth'(opd_q);
              state <= S_EXEC;
            end
`endif
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              MemAddr <= AddrWidth'(opd_q);
              state   <= S_MEM_RD;
            end
            OP_STA: begin
              MemAddr        <= AddrWidth'(opd_q);
              MemWriteEnable <= 1'b1;
              state          <= S_MEM_WR;
            end
            OP_HLT: begin
              Halted <= 1'b1;
              state  <= S_HALTED;
            end
            default: state <= S_IDLE;
          endcase
        end

        S_MEM_RD: state <= S_MEM_WAIT;

        // Read data for MemAddr is valid here (one-cycle memory latency).
        S_MEM_WAIT: begin
          m_q   <= MemRData;
          state <= S_EXEC;
        end

        S_EXEC: begin
          Carry <= exec_res[DataWidth];
          Accu  <= exec_res[DataWidth-1:0];
          Zero  <= (exec_res[DataWidth-1:0] == '0);
          state <= S_IDLE;
        end

        S_MEM_WR: state <= S_IDLE;

        S_HALTED: state <= S_HALTED;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_accu_exec_unit
//   Directed bench for accu_exec_unit with a one-cycle-latency data memory
//   model. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_accu_exec_unit;

  logic        clk;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [7:0]  MemAddr;
  logic        MemWriteEnable;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;
  logic [7:0]  Accu;
  logic        Zero;
  logic        Carry;
  logic        Halted;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];
  int         wr_count = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;

  accu_exec_unit #(.DataWidth(8), .AddrWidth(8)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .InstrValid     (InstrValid),
    .Instr          (Instr),
    .InstrReady     (InstrReady),
    .MemAddr        (MemAddr),
    .MemWriteEnable (MemWriteEnable),
    .MemWData       (MemWData),
    .MemRData       (MemRData),
    .Accu           (Accu),
    .Zero           (Zero),
    .Carry          (Carry),
    .Halted         (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: registered read, write on strobe.
  always @(posedge clk) begin
    MemRData <= mem[MemAddr];
    if (MemWriteEnable) begin
      mem[MemAddr] <= MemWData;
      wr_count     <= wr_count + 1;
      last_wa      <= MemAddr;
      last_wd      <= MemWData;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready, issues one instruction, then counts cycles
  // from the accept edge until InstrReady is high again (capped at 20).
  task automatic send(input logic [3:0] op, input logic [7:0] opd, output int lat);
    int n;
    n = 0;
    while (!InstrReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    Instr      = {op, 4'h0, opd};
    InstrValid = 1'b1;
    @(posedge clk); #1;
    InstrValid = 1'b0;
    Instr      = 16'h0000;
    lat = 0;
    while (!InstrReady && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_accu"},  {24'h0, Accu}, 32'h00);
    chk({tag, "_zero"},  {31'h0, Zero}, 32'h1);
    chk({tag, "_carry"}, {31'h0, Carry}, 32'h0);
    chk({tag, "_addr"},  {24'h0, MemAddr}, 32'h00);
    chk({tag, "_we"},    {31'h0, MemWriteEnable}, 32'h0);
    chk({tag, "_halt"},  {31'h0, Halted}, 32'h0);
    chk({tag, "_ready"}, {31'h0, InstrReady}, 32'h0);
    chk({tag, "_wdata"}, {24'h0, MemWData}, 32'h00);
  endtask

  initial begin
    int lat;
    int wc;
    logic [7:0] addr_before;

    Reset      = 1'b1;
    InstrValid = 1'b0;
    Instr      = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hF0;
    mem[8'h21] = 8'h05;
    mem[8'h22] = 8'h0F;

    @(posedge clk); @(posedge clk); #1;
    chk_reset_vals("rst");

    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", {31'h0, InstrReady}, 32'h1);

    // LDI 0x3C
    send(4'h1, 8'h3C, lat);
    chk("ldi_lat",  lat, 3);
    chk("ldi_accu", {24'h0, Accu}, 32'h3C);
    chk("ldi_zero", {31'h0, Zero}, 32'h0);

    // LDI 0x5A ; STA 0x10
    send(4'h1, 8'h5A, lat);
    wc = wr_count;
    send(4'h3, 8'h10, lat);
    chk("sta_lat",    lat, 3);
    chk("sta_nwr",    wr_count - wc, 1);
    chk("sta_addr",   {24'h0, last_wa}, 32'h10);
    chk("sta_wdata",  {24'h0, last_wd}, 32'h5A);
    chk("sta_mem",    {24'h0, mem[8'h10]}, 32'h5A);
    chk("sta_accu",   {24'h0, Accu}, 32'h5A);
    chk("sta_we_off", {31'h0, MemWriteEnable}, 32'h0);

    // LDI 0x20 ; ADD [0x20]=F0 -> 0x110
    send(4'h1, 8'h20, lat);
    send(4'h4, 8'h20, lat);
    chk("add_lat",   lat, 5);
    chk("add_accu",  {24'h0, Accu}, 32'h10);
    chk("add_carry", {31'h0, Carry}, 32'h1);
    chk("add_zero",  {31'h0, Zero}, 32'h0);

    // LDI 0x05 ; SUB [0x21]=05 -> 0
    send(4'h1, 8'h05, lat);
    send(4'h5, 8'h21, lat);
    chk("sub0_lat",   lat, 5);
    chk("sub0_accu",  {24'h0, Accu}, 32'h00);
    chk("sub0_zero",  {31'h0, Zero}, 32'h1);
    chk("sub0_carry", {31'h0, Carry}, 32'h0);

    // LDI 0x01 ; SUB [0x21] -> 0xFC with borrow
    send(4'h1, 8'h01, lat);
    send(4'h5, 8'h21, lat);
    chk("sub1_accu",  {24'h0, Accu}, 32'hFC);
    chk("sub1_carry", {31'h0, Carry}, 32'h1);
    chk("sub1_zero",  {31'h0, Zero}, 32'h0);

    // Logic ops against [0x22]=0F; Carry stays 1 throughout
    send(4'h1, 8'h3C, lat);
    send(4'h6, 8'h22, lat);
    chk("and_accu",  {24'h0, Accu}, 32'h0C);
    chk("and_carry", {31'h0, Carry}, 32'h1);
    send(4'h7, 8'h22, lat);
    chk("or_accu",   {24'h0, Accu}, 32'h0F);
    send(4'h8, 8'h22, lat);
    chk("xor_accu",  {24'h0, Accu}, 32'h00);
    chk("xor_zero",  {31'h0, Zero}, 32'h1);

    // LDA [0x20]
    send(4'h2, 8'h20, lat);
    chk("lda_lat",   lat, 5);
    chk("lda_accu",  {24'h0, Accu}, 32'hF0);
    chk("lda_zero",  {31'h0, Zero}, 32'h0);
    chk("lda_carry", {31'h0, Carry}, 32'h1);

    // NOP and an unassigned opcode
    send(4'h0, 8'h55, lat);
    chk("nop_lat",  lat, 2);
    chk("nop_accu", {24'h0, Accu}, 32'hF0);
    send(4'hB, 8'h33, lat);
    chk("opb_lat",  lat, 2);
    chk("opb_accu", {24'h0, Accu}, 32'hF0);
    chk("opb_addr", {24'h0, MemAddr}, 32'h20);

    // LDI 0xFF ; ADDI 0x01
    send(4'h1, 8'hFF, lat);
    wc          = wr_count;
    addr_before = MemAddr;
    send(4'h9, 8'h01, lat);
`ifdef ACCU_EXEC_IMM_ALU_EN
    chk("addi_lat",   lat, 3);
    chk("addi_accu",  {24'h0, Accu}, 32'h00);
    chk("addi_carry", {31'h0, Carry}, 32'h1);
    chk("addi_zero",  {31'h0, Zero}, 32'h1);
`else
    chk("addi_lat",   lat, 2);
    chk("addi_accu",  {24'h0, Accu}, 32'hFF);
    chk("addi_carry", {31'h0, Carry}, 32'h1);
    chk("addi_zero",  {31'h0, Zero}, 32'h0);
`endif
    chk("addi_nowr",  wr_count - wc, 0);
    chk("addi_addr",  {24'h0, MemAddr}, {24'h0, addr_before});

    // HLT, then keep offering instructions for 10 cycles
    Instr      = {4'hF, 4'h0, 8'h00};
    InstrValid = 1'b1;
    @(posedge clk); #1;
    Instr = {4'h1, 4'h0, 8'h55};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hlt_halted", {31'h0, Halted}, 32'h1);
      chk("hlt_ready",  {31'h0, InstrReady}, 32'h0);
      chk("hlt_we",     {31'h0, MemWriteEnable}, 32'h0);
    end
    InstrValid = 1'b0;
    Instr      = 16'h0000;
`ifdef ACCU_EXEC_IMM_ALU_EN
    chk("hlt_accu", {24'h0, Accu}, 32'h00);
`else
    chk("hlt_accu", {24'h0, Accu}, 32'hFF);
`endif

    // Reset out of HALTED
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("unhalt_halted", {31'h0, Halted}, 32'h0);
    chk("unhalt_ready",  {31'h0, InstrReady}, 32'h1);

    // LDI 0x77 ; STA 0x30 interrupted by Reset during MEM_WR
    send(4'h1, 8'h77, lat);
    wc         = wr_count;
    Instr      = {4'h3, 4'h0, 8'h30};
    InstrValid = 1'b1;
    @(posedge clk); #1;          // accept -> DECODE
    InstrValid = 1'b0;
    Instr      = 16'h0000;
    @(posedge clk); #1;          // DECODE -> MEM_WR
    chk("mwr_we",    {31'h0, MemWriteEnable}, 32'h1);
    chk("mwr_addr",  {24'h0, MemAddr}, 32'h30);
    chk("mwr_wdata", {24'h0, MemWData}, 32'h77);
    Reset = 1'b1;
    #1;                          // well before the next rising edge
    chk_reset_vals("arst");
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("arst_nowr",  wr_count - wc, 0);
    chk("arst_mem",   {24'h0, mem[8'h30]}, 32'h00);
    chk("arst_ready", {31'h0, InstrReady}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
